// File: rtl/adam_aes_pkg.sv
// Shared constants, FSM encoding and GF(2^8) helpers for the AES inverse cipher.
package adam_aes_pkg;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES_128_NUM_ROUNDS = 4'd10;
    localparam logic [3:0] AES_256_NUM_ROUNDS = 4'd14;

    typedef enum logic [1:0] {
        CTRL_IDLE = 2'd0,
        CTRL_INIT = 2'd1,
        CTRL_SBOX = 2'd2,
        CTRL_MAIN = 2'd3
    } dec_ctrl_t;

    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    function automatic logic [7:0] gm4(input logic [7:0] b);
        return gm2(gm2(b));
    endfunction

    function automatic logic [7:0] gm8(input logic [7:0] b);
        return gm2(gm4(b));
    endfunction

    // One column of InvMixColumns: rows use 0e/0b/0d/09 rotated per row.
    function automatic logic [31:0] inv_mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] m0, m1, m2, m3;
        {b0, b1, b2, b3} = w;
        m0 = (gm8(b0) ^ gm4(b0) ^ gm2(b0)) ^ (gm8(b1) ^ gm2(b1) ^ b1) ^
             (gm8(b2) ^ gm4(b2) ^ b2) ^ (gm8(b3) ^ b3);
        m1 = (gm8(b0) ^ b0) ^ (gm8(b1) ^ gm4(b1) ^ gm2(b1)) ^
             (gm8(b2) ^ gm2(b2) ^ b2) ^ (gm8(b3) ^ gm4(b3) ^ b3);
        m2 = (gm8(b0) ^ gm4(b0) ^ b0) ^ (gm8(b1) ^ b1) ^
             (gm8(b2) ^ gm4(b2) ^ gm2(b2)) ^ (gm8(b3) ^ gm2(b3) ^ b3);
        m3 = (gm8(b0) ^ gm2(b0) ^ b0) ^ (gm8(b1) ^ gm4(b1) ^ b1) ^
             (gm8(b2) ^ b2) ^ (gm8(b3) ^ gm4(b3) ^ gm2(b3));
        return {m0, m1, m2, m3};
    endfunction

    function automatic logic [127:0] inv_mixcolumns(input logic [127:0] s);
        return {inv_mixw(s[127:96]), inv_mixw(s[95:64]),
                inv_mixw(s[63:32]), inv_mixw(s[31:0])};
    endfunction

    // Row r of the state is rotated right by r columns.
    function automatic logic [127:0] inv_shiftrows(input logic [127:0] s);
        logic [31:0] w0, w1, w2, w3;
        {w0, w1, w2, w3} = s;
        return {w0[31:24], w3[23:16], w2[15:8], w1[7:0],
                w1[31:24], w0[23:16], w3[15:8], w2[7:0],
                w2[31:24], w1[23:16], w0[15:8], w3[7:0],
                w3[31:24], w2[23:16], w1[15:8], w0[7:0]};
    endfunction

endpackage

// File: rtl/adam_aes_inv_sbox.sv
// Four parallel AES inverse S-box lookups on one 32-bit word.
module adam_aes_inv_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign new_sboxw = {INV_SBOX[sboxw[31:24]], INV_SBOX[sboxw[23:16]],
                        INV_SBOX[sboxw[15:8]],  INV_SBOX[sboxw[7:0]]};

endmodule

// File: rtl/adam_aes_decipher_block.sv
// Iterative AES-128/256 inverse cipher; reads round keys by index from the key memory.
// Handshake: next is accepted only on an edge where ready=1; ready then drops and rises
// again when new_block holds the plaintext, which stays stable until the next completion.
module adam_aes_decipher_block
    import adam_aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         next,
    input  logic         keylen,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [127:0] new_block,
    output logic         ready
);

    dec_ctrl_t    state_reg;
    logic [127:0] block_reg;
    logic [127:0] new_block_reg;
    logic         ready_reg;
    logic [3:0]   round_ctr_reg;
    logic [1:0]   word_ctr_reg;

    logic [31:0]  sbox_word;
    logic [31:0]  sbox_new_word;
    logic [127:0] add_key;

    assign add_key   = block_reg ^ round_key;
    assign round     = round_ctr_reg;
    assign new_block = new_block_reg;
    assign ready     = ready_reg;

    always_comb begin
        sbox_word = block_reg[127:96];
        case (word_ctr_reg)
            2'd0: sbox_word = block_reg[127:96];
            2'd1: sbox_word = block_reg[95:64];
            2'd2: sbox_word = block_reg[63:32];
            2'd3: sbox_word = block_reg[31:0];
            default: sbox_word = block_reg[127:96];
        endcase
    end

    adam_aes_inv_sbox u_inv_sbox (
        .sboxw     (sbox_word),
        .new_sboxw (sbox_new_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= CTRL_IDLE;
            block_reg     <= '0;
            new_block_reg <= '0;
            ready_reg     <= 1'b1;
            round_ctr_reg <= '0;
            word_ctr_reg  <= '0;
        end else begin
            case (state_reg)
                CTRL_IDLE: begin
                    if (next) begin
                        block_reg     <= block;
                        round_ctr_reg <= (keylen == AES_256_BIT_KEY) ? AES_256_NUM_ROUNDS
                                                                     : AES_128_NUM_ROUNDS;
                        ready_reg     <= 1'b0;
                        state_reg     <= CTRL_INIT;
                    end
                end

                CTRL_INIT: begin
                    block_reg     <= inv_shiftrows(add_key);
                    round_ctr_reg <= round_ctr_reg - 4'd1;
                    word_ctr_reg  <= '0;
                    state_reg     <= CTRL_SBOX;
                end

                // InvShiftRows was already applied, so the byte-wise S-box can follow it.
                CTRL_SBOX: begin
                    case (word_ctr_reg)
                        2'd0: block_reg[127:96] <= sbox_new_word;
                        2'd1: block_reg[95:64]  <= sbox_new_word;
                        2'd2: block_reg[63:32]  <= sbox_new_word;
                        2'd3: block_reg[31:0]   <= sbox_new_word;
                        default: block_reg[127:96] <= sbox_new_word;
                    endcase
                    word_ctr_reg <= word_ctr_reg + 2'd1;
                    if (word_ctr_reg == 2'd3) begin
                        state_reg <= CTRL_MAIN;
                    end
                end

                CTRL_MAIN: begin
                    if (round_ctr_reg != 4'd0) begin
                        block_reg     <= inv_shiftrows(inv_mixcolumns(add_key));
                        round_ctr_reg <= round_ctr_reg - 4'd1;
                        state_reg     <= CTRL_SBOX;
                    end else begin
                        new_block_reg <= add_key;
                        ready_reg     <= 1'b1;
                        state_reg     <= CTRL_IDLE;
                    end
                end

                default: state_reg <= CTRL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adam_aes_decipher_block.sv
// Directed FIPS-197 vectors against the inverse cipher, with a behavioural key memory.
module tb_adam_aes_decipher_block;

    logic         clk;
    logic         rst;
    logic         next;
    logic         keylen;
    logic [127:0] block;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] new_block;
    logic         ready;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY2 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KEY3 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT2  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT3  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT12 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT3  = 128'h3243f6a8885a308d313198a2e0370734;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Key memory: combinational read of the expanded round key selected by 'round'.
    logic [127:0] rk [0:14];
    assign round_key = (round <= 4'd14) ? rk[round] : '0;

    adam_aes_decipher_block dut (
        .clk       (clk),
        .rst       (rst),
        .next      (next),
        .keylen    (keylen),
        .block     (block),
        .round     (round),
        .round_key (round_key),
        .new_block (new_block),
        .ready     (ready)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- key memory model ----------------
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    task automatic load_key(input logic [255:0] key, input logic aes256);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rcon;
        int nk;
        int nw;
        nk   = aes256 ? 8 : 4;
        nw   = aes256 ? 60 : 44;
        rcon = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
            end else if (nk == 8 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++)
            rk[r] = (4*r + 3 < nw) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // ---------------- driver tasks (entered and left just after a falling edge) ----------------
    task automatic start_op(input logic [127:0] blk, input logic kl);
        next   = 1'b1;
        block  = blk;
        keylen = kl;
        @(posedge clk);
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [127:0] blk, input logic [127:0] exp_pt,
                             input int exp_lat, input int pulse_at, input bit chk_rounds,
                             input bit chk_hold, input logic [127:0] hold_val);
        int lat;
        int nr;
        lat = 0;
        nr  = (exp_lat - 1) / 5;
        check({tag, "_busy"}, 128'(ready), 128'(0));
        if (chk_rounds) check({tag, "_round_init"}, 128'(round), 128'(nr));
        if (chk_hold) check({tag, "_hold_start"}, new_block, hold_val);
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            next = (n == pulse_at);
            if (n == pulse_at) begin
                block  = ~blk;
                keylen = ~keylen;
            end
            @(posedge clk);
            @(negedge clk);
            if (ready) begin
                lat = n;
            end else if (n < exp_lat) begin
                if (chk_rounds) check({tag, "_round"}, 128'(round), 128'(nr - 1 - (n - 1) / 5));
                if (chk_hold && (n % 10 == 0 || n == exp_lat - 1))
                    check({tag, "_hold"}, new_block, hold_val);
            end
        end
        next = 1'b0;
        if (lat == 0) lat = 999;
        check({tag, "_latency"}, 128'(lat), 128'(exp_lat));
        check({tag, "_result"}, new_block, exp_pt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst    = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = '0;
        for (int r = 0; r < 15; r++) rk[r] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 128'(ready), 128'(1));
        check("reset_new_block", new_block, '0);
        check("reset_round", 128'(round), 128'(0));
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1, AES-128
        load_key({KEY1, 128'h0}, 1'b0);
        start_op(CT1, 1'b0);
        wait_done("aes128_c1", CT1, PT12, 51, 0, 1'b0, 1'b0, '0);

        // FIPS-197 C.3, AES-256
        load_key(KEY2, 1'b1);
        start_op(CT2, 1'b1);
        wait_done("aes256_c3", CT2, PT12, 71, 0, 1'b0, 1'b0, '0);

        // FIPS-197 B, AES-128, then result held while idle
        load_key({KEY3, 128'h0}, 1'b0);
        start_op(CT3, 1'b0);
        wait_done("aes128_b", CT3, PT3, 51, 0, 1'b0, 1'b0, '0);
        repeat (3) @(negedge clk);
        check("idle_hold_result", new_block, PT3);
        check("idle_ready", 128'(ready), 128'(1));

        // Round index sequence, with a next pulse (and altered inputs) while busy
        load_key({KEY1, 128'h0}, 1'b0);
        start_op(CT1, 1'b0);
        wait_done("rounds_busy_next", CT1, PT12, 51, 17, 1'b1, 1'b0, '0);
        check("post_op_round", 128'(round), 128'(0));

        // Reset mid-operation, then a clean run
        start_op(CT1, 1'b0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midop_reset_ready", 128'(ready), 128'(1));
        check("midop_reset_new_block", new_block, '0);
        check("midop_reset_round", 128'(round), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        start_op(CT1, 1'b0);
        wait_done("after_reset", CT1, PT12, 51, 0, 1'b0, 1'b0, '0);

        // Back-to-back: second next on the cycle ready rises
        load_key({KEY3, 128'h0}, 1'b0);
        start_op(CT3, 1'b0);
        wait_done("b2b_first", CT3, PT3, 51, 0, 1'b0, 1'b0, '0);
        load_key({KEY1, 128'h0}, 1'b0);
        start_op(CT1, 1'b0);
        wait_done("b2b_second", CT1, PT12, 51, 0, 1'b0, 1'b1, PT3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
